// File: rtl/step_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : step_ctrl_if
//  Description : Button / CPU-control bundle between the board-level button
//                source and step_ctrl.
//  Ports       : btn_run, btn_step  raw push buttons (master -> slave)
//                stop               CPU halt level   (slave -> master)
//                step_pulse         one-cycle CPU advance request
//                run_led            high while free-running
//                step_count [15:0]  accepted steps since reset, mod 2^16
//  Revision    : 1.0  initial release
// ============================================================================
interface step_ctrl_if;
    logic        btn_run;
    logic        btn_step;
    logic        stop;
    logic        step_pulse;
    logic        run_led;
    logic [15:0] step_count;

    modport master (
        output btn_run,
        output btn_step,
        input  stop,
        input  step_pulse,
        input  run_led,
        input  step_count
    );

    modport slave (
        input  btn_run,
        input  btn_step,
        output stop,
        output step_pulse,
        output run_led,
        output step_count
    );
endinterface
`default_nettype wire

// File: rtl/step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : step_ctrl
//  Description : Run / halt / single-step controller for a CPU. Two raw push
//                buttons are synchronised, debounced and edge-detected; a
//                HALT/RUN/STEP state machine drives the CPU stop level and a
//                one-cycle step request, and counts accepted steps.
//  Ports       : clk_board  board clock, all state on its rising edge
//                rst        asynchronous active-high reset
//                bus        step_ctrl_if.slave (buttons in, control out)
//  Parameters  : DB_CYCLES  cycles a level must persist to be accepted
//                DB_W       debounce counter width
//  Revision    : 1.0  initial release
// ============================================================================
module step_ctrl #(
    parameter int DB_CYCLES = 1000000,
    parameter int DB_W      = 20
) (
    input  wire logic  clk_board,
    input  wire logic  rst,
    step_ctrl_if.slave bus
);

    localparam logic [DB_W-1:0] c_DB_LAST = DB_W'(DB_CYCLES - 1);

    localparam logic [1:0] c_HALT = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_STEP = 2'd2;

    // Index 0 = run button, index 1 = step button.
    logic [1:0] w_btn_raw;
    logic [1:0] w_press;

    assign w_btn_raw = {bus.btn_step, bus.btn_run};

    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic            r_meta;
        logic            r_sync;
        logic            r_db;
        logic            r_db_prev;
        logic [DB_W-1:0] r_cnt;

        always_ff @(posedge clk_board or posedge rst) begin
            if (rst) begin
                r_meta    <= 1'b0;
                r_sync    <= 1'b0;
                r_db      <= 1'b0;
                r_db_prev <= 1'b0;
                r_cnt     <= '0;
            end else begin
                r_meta    <= w_btn_raw[i];
                r_sync    <= r_meta;
                r_db_prev <= r_db;
                // Any cycle where sync agrees with db restarts the count, so
                // only an uninterrupted run of DB_CYCLES disagreeing cycles
                // moves the debounced level.
                if (r_sync == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_LAST) begin
                    r_db  <= r_sync;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        // Press only; releases are not events.
        assign w_press[i] = r_db & ~r_db_prev;
    end

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [15:0] r_step_count;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_HALT: begin
                // Run wins over a simultaneous step.
                if (w_press[0])      w_state_next = c_RUN;
                else if (w_press[1]) w_state_next = c_STEP;
            end
            c_RUN: begin
                if (w_press[0])      w_state_next = c_HALT;
            end
            c_STEP: begin
                // Presses landing in this cycle are dropped on purpose.
                w_state_next = c_HALT;
            end
            default: w_state_next = c_HALT;
        endcase
    end

    always_ff @(posedge clk_board or posedge rst) begin
        if (rst) begin
            r_state      <= c_HALT;
            r_step_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == c_STEP) begin
                r_step_count <= r_step_count + 16'd1;
            end
        end
    end

    // Purely state-decoded outputs: no input reaches them combinationally.
    assign bus.stop       = (r_state == c_HALT);
    assign bus.step_pulse = (r_state == c_STEP);
    assign bus.run_led    = (r_state == c_RUN);
    assign bus.step_count = r_step_count;

endmodule
`default_nettype wire

// File: doc/step_ctrl.md
STEP_CTRL -- requirements
Module: step_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 1000000, is the number of consecutive clk_board cycles a synchronized button level must differ from its debounced level before the debounced level changes; legal range 2..2^DB_W-1.
REQ-002 Parameter DB_W, default 20, is the width of each debounce counter.
REQ-003 clk_board  input  1  board clock; the only clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 btn_run  input  1  raw run/stop push button, asynchronous to clk_board, bouncing, high = pressed.
REQ-006 btn_step  input  1  raw single-step push button, asynchronous to clk_board, bouncing, high = pressed.
REQ-007 stop  output  1  CPU halt level for the top level's stop input; 1 = CPU frozen.
REQ-008 step_pulse  output  1  single-cycle CPU advance request; high for exactly one clk_board cycle per accepted step.
REQ-009 run_led  output  1  high while in RUN.
REQ-010 step_count  output  16  number of accepted steps since reset, modulo 2^16.

Function
REQ-011 Each button SHALL pass through its own 2-flop synchronizer before any other logic uses it.
REQ-012 Each button SHALL have one debouncer: a counter plus a debounced level, with sync = synchronizer output and db = debounced level.
REQ-013 Debouncer, per cycle: sync == db -> cnt <= 0; sync != db and cnt < DB_CYCLES-1 -> cnt <= cnt+1; sync != db and cnt == DB_CYCLES-1 -> db <= sync, cnt <= 0.
REQ-014 A pulse or bounce on sync shorter than DB_CYCLES cycles SHALL leave db unchanged.
REQ-015 Press event = db rising edge (db == 1 and previous-cycle db == 0), evaluated with one register stage; releases generate no event.
REQ-016 FSM states: HALT, RUN, STEP.
REQ-017 HALT: run press -> RUN; else step press -> STEP; else stay.
REQ-018 RUN: run press -> HALT; step presses ignored.
REQ-019 STEP: unconditionally -> HALT after one cycle; run and step presses arriving in this cycle are discarded.
REQ-020 A run press and a step press in the same cycle in HALT -> RUN; the step is dropped.
REQ-021 Outputs decoded from registered state only, no combinational path from inputs: stop = (state == HALT); step_pulse = (state == STEP); run_led = (state == RUN).
REQ-022 stop = 0 in STEP, so the CPU clock is enabled for exactly one cycle per step.
REQ-023 step_count increments by 1 in each cycle where state == STEP and wraps 0xFFFF -> 0x0000 with no flag.
REQ-024 Latency: if a btn_step press is first sampled at clock edge 1 and held, step_pulse is high from edge DB_CYCLES+3 to edge DB_CYCLES+4.

Reset
REQ-025 rst SHALL asynchronously force: state = HALT, synchronizers = 0, db = 0, cnt = 0, edge registers = 0, step_count = 0.
REQ-026 Output values during and immediately after reset: stop = 1, step_pulse = 0, run_led = 0, step_count = 0.
REQ-027 rst asserted mid-debounce or in STEP SHALL abort the operation with no step_pulse and no count increment.
REQ-028 A button held through reset release SHALL be treated as a fresh press once debounced.

Verification (DB_CYCLES = 4)
REQ-029 Reset, then btn_step held high from edge 1 -> step_pulse = 1 only between edges 7 and 8; stop = 0 in that cycle only; step_count = 1.
REQ-030 btn_step high for 3 cycles, then low -> no step_pulse; step_count stays 0.
REQ-031 btn_run pressed and released, then btn_step pressed -> run_led = 1, stop = 0, step ignored; btn_run pressed again -> stop = 1, run_led = 0.
REQ-032 btn_run and btn_step rise in the same cycle from HALT -> RUN entered, no step_pulse, step_count unchanged.
REQ-033 Preload by 65535 steps, then one more step -> step_count = 0x0000.
REQ-034 rst pulsed while state = RUN and while cnt = 2 -> stop = 1 asynchronously, cnt = 0, no pulse emitted.
